// File: rtl/mu0_pkg.sv
// Shared types and widths for the MU0 accumulator processor.
package mu0_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_STA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_JMP = 4'h4,
        OP_JGE = 4'h5,
        OP_JNE = 4'h6,
        OP_STP = 4'h7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB
    } alu_op_e;

endpackage

// File: rtl/mu0_alu.sv
// Combinational accumulator ALU: pass-through (LDA), add and subtract, 16-bit wrapping.
module mu0_alu
    import mu0_pkg::*;
(
    input  alu_op_e           i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_operand,
    output logic [DATA_W-1:0] o_result
);

    always_comb begin
        case (i_op)
            ALU_ADD: o_result = i_acc + i_operand;
            ALU_SUB: o_result = i_acc - i_operand;
            default: o_result = i_operand;
        endcase
    end

endmodule

// File: rtl/mu0_multicycle_cpu.sv
// MU0 multicycle CPU: FETCH/DECODE/EXEC sequencing over a single synchronous RAM port.
module mu0_multicycle_cpu
    import mu0_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC      = 12'h000,
    parameter bit                HALT_ON_UNDEF = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              running,
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic              read,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
);

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] w_instr;
    logic [DATA_W-1:0] w_alu_result;
    logic [ADDR_W-1:0] w_operand;
    opcode_e           w_op;
    alu_op_e           w_alu_op;
    logic              w_ir_load;
    logic              w_acc_load;

    // During DECODE the instruction is still on readdata; afterwards it lives in IR.
    assign w_instr   = (r_state == S_DECODE) ? readdata : r_ir;
    assign w_op      = opcode_e'(w_instr[DATA_W-1 -: 4]);
    assign w_operand = w_instr[ADDR_W-1:0];
    assign writedata = r_acc;

    always_comb begin
        case (w_op)
            OP_ADD:  w_alu_op = ALU_ADD;
            OP_SUB:  w_alu_op = ALU_SUB;
            default: w_alu_op = ALU_PASS;
        endcase
    end

    mu0_alu u_alu (
        .i_op      (w_alu_op),
        .i_acc     (r_acc),
        .i_operand (readdata),
        .o_result  (w_alu_result)
    );

    // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_ir_load    = 1'b0;
        w_acc_load   = 1'b0;
        running      = 1'b0;
        read         = 1'b0;
        write        = 1'b0;
        address      = '0;
        case (r_state)
            S_IDLE: w_next_state = S_FETCH;
            S_FETCH: begin
                running      = 1'b1;
                read         = 1'b1;
                address      = r_pc;
                w_pc_next    = r_pc + 12'd1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                running      = 1'b1;
                w_ir_load    = 1'b1;
                w_next_state = S_FETCH;
                case (w_op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        read         = 1'b1;
                        address      = w_operand;
                        w_next_state = S_EXEC;
                    end
                    OP_STA: begin
                        write   = 1'b1;
                        address = w_operand;
                    end
                    OP_JMP: w_pc_next = w_operand;
                    OP_JGE: if (!r_acc[DATA_W-1]) w_pc_next = w_operand;
                    OP_JNE: if (r_acc != '0) w_pc_next = w_operand;
                    OP_STP: w_next_state = S_HALT;
                    default: w_next_state = HALT_ON_UNDEF ? S_HALT : S_FETCH;
                endcase
            end
            S_EXEC: begin
                running      = 1'b1;
                w_acc_load   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_acc   <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            if (w_ir_load)  r_ir  <= readdata;
            if (w_acc_load) r_acc <= w_alu_result;
        end
    end

endmodule

// File: tb/tb_mu0_multicycle_cpu.sv
// Bench: two CPUs (halt-on-undefined on/off) on private RAMs, scored against an ISA-level model.
module tb_mu0_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_req = 1'b0;
    logic [15:0] img   [4096];
    logic [15:0] mem_a [4096];
    logic [15:0] mem_b [4096];

    logic        a_running, a_write, a_read;
    logic [11:0] a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_running, b_write, b_read;
    logic [11:0] b_addr;
    logic [15:0] b_wdata, b_rdata;

    logic [27:0] a_wlog[$];
    logic [27:0] b_wlog[$];
    logic [27:0] exp_wlog[$];
    int          a_cyc, b_cyc;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;

    mu0_multicycle_cpu #(.RESET_PC(12'h000), .HALT_ON_UNDEF(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .running(a_running), .address(a_addr), .write(a_write),
        .read(a_read), .writedata(a_wdata), .readdata(a_rdata)
    );

    mu0_multicycle_cpu #(.RESET_PC(12'h000), .HALT_ON_UNDEF(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .running(b_running), .address(b_addr), .write(b_write),
        .read(b_read), .writedata(b_wdata), .readdata(b_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_req) begin
            mem_a <= img;
            mem_b <= img;
        end else begin
            if (a_read)  a_rdata <= mem_a[a_addr];
            if (a_write) mem_a[a_addr] <= a_wdata;
            if (b_read)  b_rdata <= mem_b[b_addr];
            if (b_write) mem_b[b_addr] <= b_wdata;
        end
    end

    // Counts running cycles and logs every store, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            a_cyc <= 0;
            b_cyc <= 0;
            a_wlog.delete();
            b_wlog.delete();
        end else begin
            if (a_running) a_cyc <= a_cyc + 1;
            if (b_running) b_cyc <= b_cyc + 1;
            if (a_write) a_wlog.push_back({a_addr, a_wdata});
            if (b_write) b_wlog.push_back({b_addr, b_wdata});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction-set interpreter: final ACC, running cycles and the ordered store list.
    task automatic model(input bit hou, output logic [15:0] acc, output int cyc);
        logic [15:0] m [4096];
        logic [11:0] pc;
        logic [15:0] ins;
        logic [11:0] s;
        bit          done;
        m = img;
        pc = 12'h000;
        acc = 16'h0;
        cyc = 0;
        done = 1'b0;
        exp_wlog.delete();
        for (int step = 0; step < 4000 && !done; step++) begin
            ins = m[pc];
            pc  = pc + 12'd1;
            s   = ins[11:0];
            case (ins[15:12])
                4'h0: begin acc = m[s];       cyc += 3; end
                4'h1: begin m[s] = acc; exp_wlog.push_back({s, acc}); cyc += 2; end
                4'h2: begin acc = acc + m[s]; cyc += 3; end
                4'h3: begin acc = acc - m[s]; cyc += 3; end
                4'h4: begin pc = s; cyc += 2; end
                4'h5: begin if ($signed(acc) >= 0) pc = s; cyc += 2; end
                4'h6: begin if (acc != 16'h0) pc = s; cyc += 2; end
                4'h7: begin done = 1'b1; cyc += 2; end
                default: begin cyc += 2; if (hou) done = 1'b1; end
            endcase
        end
    endtask

    task automatic score(input string tag, input bit hou);
        logic [15:0] e_acc;
        int          e_cyc;
        logic [27:0] obs[$];
        logic [15:0] o_acc;
        int          o_cyc;
        logic        o_run;
        string       t;
        model(hou, e_acc, e_cyc);
        t = hou ? {tag, "/halt"} : {tag, "/nop"};
        if (hou) begin
            obs = a_wlog; o_acc = a_wdata; o_cyc = a_cyc; o_run = a_running;
        end else begin
            obs = b_wlog; o_acc = b_wdata; o_cyc = b_cyc; o_run = b_running;
        end
        check({t, " acc"}, o_acc, e_acc);
        check({t, " cycles"}, o_cyc, e_cyc);
        check({t, " running"}, o_run, 1'b0);
        check({t, " nwrites"}, obs.size(), exp_wlog.size());
        for (int i = 0; i < exp_wlog.size() && i < obs.size(); i++)
            check({t, " write"}, obs[i], exp_wlog[i]);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 4096; i++) img[i] = 16'h0000;
    endtask

    task automatic start_prog();
        rst = 1'b0;
        load_req = 1'b1;
        repeat (2) @(posedge clk);
        load_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic finish_prog(input string tag);
        bit halted = 1'b0;
        for (int i = 0; i < 3000 && !halted; i++) begin
            @(negedge clk);
            if (!a_running && !b_running) halted = 1'b1;
        end
        check({tag, " halted"}, halted, 1'b1);
        @(posedge clk);
        #1;
        score(tag, 1'b1);
        score(tag, 1'b0);
    endtask

    task automatic gen_random();
        int n;
        clear_img();
        n = $urandom_range(12, 4);
        for (int a = 0; a < n; a++) begin
            case ($urandom_range(9, 0))
                0, 1:    img[a] = {4'h0, 12'h100 + 12'($urandom_range(15, 0))};
                2:       img[a] = {4'h1, 12'h100 + 12'($urandom_range(15, 0))};
                3:       img[a] = {4'h2, 12'h100 + 12'($urandom_range(15, 0))};
                4:       img[a] = {4'h3, 12'h100 + 12'($urandom_range(15, 0))};
                5:       img[a] = {4'h4, 12'($urandom_range(n, a + 1))};
                6:       img[a] = {4'h5, 12'($urandom_range(n, a + 1))};
                7:       img[a] = {4'h6, 12'($urandom_range(n, a + 1))};
                8:       img[a] = {4'($urandom_range(15, 8)), 12'($urandom)};
                default: img[a] = {4'h2, 12'h100 + 12'($urandom_range(15, 0))};
            endcase
        end
        img[n] = 16'h7000;
        for (int d = 0; d < 16; d++) begin
            case ($urandom_range(5, 0))
                0:       img[256 + d] = 16'h0000;
                1:       img[256 + d] = 16'h0001;
                2:       img[256 + d] = 16'h7FFF;
                3:       img[256 + d] = 16'h8000;
                4:       img[256 + d] = 16'hFFFF;
                default: img[256 + d] = 16'($urandom);
            endcase
        end
    endtask

    initial begin
        bit saw_write;

        // Reset state and first fetch; program is a lone STP.
        clear_img();
        img[0] = 16'h7000;
        rst = 1'b0;
        #2;
        check("reset running", a_running, 1'b0);
        check("reset read", a_read, 1'b0);
        check("reset write", a_write, 1'b0);
        check("reset address", a_addr, 12'h000);
        check("reset writedata", a_wdata, 16'h0000);
        start_prog();
        @(negedge clk);
        check("first fetch running", a_running, 1'b1);
        check("first fetch read", a_read, 1'b1);
        check("first fetch address", a_addr, 12'h000);
        finish_prog("stp only");

        // LDA/SUB/STA/STP: 5 - 7 stored at 012.
        clear_img();
        img[0] = 16'h0010; img[1] = 16'h3011; img[2] = 16'h1012; img[3] = 16'h7000;
        img[16] = 16'h0005; img[17] = 16'h0007;
        start_prog();
        finish_prog("sub store");
        check("sub store pulse", (a_wlog.size() == 1) ? a_wlog[0] : 28'h0, {12'h012, 16'hFFFE});

        // Countdown loop: 3 SUB iterations then ACC=0.
        clear_img();
        img[0] = 16'h0020; img[1] = 16'h3021; img[2] = 16'h6001; img[3] = 16'h7000;
        img[32] = 16'h0003; img[33] = 16'h0001;
        start_prog();
        finish_prog("countdown");
        check("countdown acc", a_wdata, 16'h0000);
        check("countdown cycles", a_cyc, 3 + 3 * (3 + 2) + 2);

        // JGE on 8000 falls through, on 7FFF jumps; FFFF+0001 wraps to 0.
        clear_img();
        img[0] = 16'h0020; img[1] = 16'h5003; img[2] = 16'h1030; img[3] = 16'h0021;
        img[4] = 16'h5006; img[5] = 16'h7000; img[6] = 16'h0022; img[7] = 16'h2023;
        img[8] = 16'h1031; img[9] = 16'h7000;
        img[32] = 16'h8000; img[33] = 16'h7FFF; img[34] = 16'hFFFF; img[35] = 16'h0001;
        start_prog();
        finish_prog("jge wrap");
        check("jge fallthrough store", (a_wlog.size() == 2) ? a_wlog[0] : 28'h0, {12'h030, 16'h8000});
        check("add wrap store", (a_wlog.size() == 2) ? a_wlog[1] : 28'h0, {12'h031, 16'h0000});

        // PC wraps from FFF to 000.
        clear_img();
        img[0] = 16'h6003; img[1] = 16'h0020; img[2] = 16'h4FFF; img[3] = 16'h1030;
        img[4] = 16'h7000; img[4095] = 16'h2020; img[32] = 16'h0005;
        start_prog();
        finish_prog("pc wrap");

        // Undefined opcode: halts on DUT a, skipped on DUT b.
        clear_img();
        img[0] = 16'h0020; img[1] = 16'h9ABC; img[2] = 16'h1030; img[3] = 16'h7000;
        img[32] = 16'h1234;
        start_prog();
        finish_prog("undef");
        check("undef halt writes", a_wlog.size(), 0);
        check("undef nop store", (b_wlog.size() == 1) ? b_wlog[0] : 28'h0, {12'h030, 16'h1234});

        // Reset asserted while the store strobe is high aborts the store.
        clear_img();
        img[0] = 16'h0020; img[1] = 16'h1030; img[2] = 16'h7000;
        img[32] = 16'h1234; img[48] = 16'hBEEF;
        start_prog();
        saw_write = 1'b0;
        for (int i = 0; i < 20 && !saw_write; i++) begin
            @(negedge clk);
            if (a_write) saw_write = 1'b1;
        end
        check("abort saw write", saw_write, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("abort write low", a_write, 1'b0);
        check("abort running low", a_running, 1'b0);
        check("abort address", a_addr, 12'h000);
        check("abort acc", a_wdata, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("abort mem kept", mem_a[48], 16'hBEEF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("restart read", a_read, 1'b1);
        check("restart address", a_addr, 12'h000);
        check("restart acc", a_wdata, 16'h0000);
        finish_prog("abort restart");

        // Random forward-branching programs.
        for (int k = 0; k < 10; k++) begin
            gen_random();
            start_prog();
            finish_prog($sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
